temp_sample_sequencer: RTL
==========================

// Module: temp_sample_sequencer
// PURPOSE
//   Front-end controller for the temperature monitor. Accepts signed BCD temperature samples over a
//   valid/ready handshake and keeps the previous sample. Computes the signed BCD delta digit-serially,
//   then drives the value/delta buses and the monitor enable for a fixed window. Captures the
//   monitor's classified state and reports it. Also flags samples that stop arriving.
// PARAMETERS
//   EN_HOLD        4     cycles mon_en is held high per sample (>=1)
//   TIMEOUT_CYCLES 0     idle cycles with no accepted sample before timeout is raised; 0 disables
//   TW             24    width of timeout counter (must hold TIMEOUT_CYCLES)
// PORTS
//   clk          in   1   system clock, all state on rising edge
//   rst          in   1   reset, asynchronous, active-high
//   sample_valid in   1   new sample offered
//   sample_ready out  1   sequencer can accept; transfer when valid&ready at clk edge
//   sample_bcd   in   12  {huns,tens,ones} BCD magnitude
//   sample_sign  in   1   1 = negative
//   value_bcd    out  12  current sample magnitude to monitor
//   value_sign   out  1   current sample sign to monitor
//   delta_bcd    out  12  |new - prev| BCD, saturated to 999
//   delta_sign   out  1   1 = new < prev
//   mon_en       out  1   monitor enable / "new value" strobe
//   mon_state    in   2   monitor classification, sampled at end of enable window
//   state_out    out  2   last captured classification
//   state_valid  out  1   one-cycle pulse when state_out updates
//   bad_sample   out  1   one-cycle pulse: accepted sample had a digit > 9
//   timeout      out  1   sticky: no sample for TIMEOUT_CYCLES idle cycles
// BEHAVIOUR
//   Reset: every output 0, prev = +000, first flag set, timeout counter 0, FSM IDLE.
//   sample_ready = 1 only in IDLE. Valid while busy is not accepted; the source holds its data.
//   FSM: IDLE -> CMP -> SUB0 -> SUB1 -> SUB2 -> EVAL (EN_HOLD cycles) -> DONE -> IDLE.
//   Handshake at edge k:
//     - CMP in cycle k+1: magnitude compare of new vs prev; choose add or subtract.
//     - SUB0..2 in cycles k+2..k+4: ones, tens, huns, with decimal carry/borrow.
//     - EVAL in cycles k+5..k+4+EN_HOLD.
//     - DONE in cycle k+5+EN_HOLD.
//     - Next sample_ready in cycle k+6+EN_HOLD.
//   Delta arithmetic, sign-magnitude:
//     - Equal signs: magnitude = larger - smaller.
//     - Signs differ: magnitude = sum; a carry out of huns saturates to 999.
//     - delta_sign = 1 iff new < prev as signed values. Zero delta gives sign 0. -000 equals +000.
//   First sample after reset: delta = +000; first flag cleared.
//   value_*/delta_* update only at entry to EVAL and hold until the next EVAL entry. They never change
//   while mon_en = 1. value_sign therefore toggles at most once per sample.
//   mon_en = 1 exactly during EVAL, registered, glitch-free.
//   DONE: state_out <= mon_state as sampled on the last EVAL cycle; state_valid = 1 for that cycle only.
//   prev <= new at EVAL entry.
//   Invalid BCD (any nibble > 9):
//     - Handshake completes; next cycle bad_sample = 1 and FSM returns to IDLE.
//     - No mon_en; outputs, prev and first flag unchanged.
//   Timeout:
//     - Counter increments each IDLE cycle; reaching TIMEOUT_CYCLES sets timeout (sticky).
//     - Counter and timeout clear on any accepted sample. Counter saturates.
//   Reset mid-operation: immediate abort, mon_en drops asynchronously, all state to reset values.
//   The next sample is treated as the first.
// TESTING
//   1. rst, send +025 (EN_HOLD=4):
//      value=025/+, delta=000/+; mon_en high cycles k+5..k+8; state_valid at k+9 with state_out=mon_state.
//   2. +025 then +019 -> delta 006 sign1; then +047 -> delta 028 sign0 (borrow/carry across digits).
//   3. Sign crossings:
//      - +003 then -004 -> delta 007 sign1.
//      - -600 then +500 -> 999 sign0 (saturated).
//      - Toggle sign on -000/+000 -> delta 000 sign0.
//   4. sample_bcd=12'h0A5 -> bad_sample pulse, no mon_en, value/delta/prev unchanged; ready back next cycle.
//   5. TIMEOUT_CYCLES=20, no samples -> timeout=1 after 20 idle cycles; next accepted sample clears it.
//      Also hold valid while busy -> exactly one transfer per sample.
//   6. rst pulsed during EVAL -> mon_en and all outputs 0 at once; next sample gives delta 000 (first).

Source files
------------

// File: rtl/temp_sample_sequencer.sv
// Temperature monitor front end: takes signed BCD samples, forms the digit-serial signed delta
// against the previous sample, drives the monitor for a fixed window and reports its classification.
module temp_sample_sequencer #(
   parameter int EN_HOLD        = 4,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TW             = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   output logic        sample_ready,
   input  logic [11:0] sample_bcd,
   input  logic        sample_sign,
   output logic [11:0] value_bcd,
   output logic        value_sign,
   output logic [11:0] delta_bcd,
   output logic        delta_sign,
   output logic        mon_en,
   input  logic [1:0]  mon_state,
   output logic [1:0]  state_out,
   output logic        state_valid,
   output logic        bad_sample,
   output logic        timeout
);

   localparam int HW = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(EN_HOLD - 1);
   localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_MAX    = {TW{1'b1}};
   localparam bit            TO_ENABLE = (TIMEOUT_CYCLES > 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMP  = 3'd1,
      S_SUB0 = 3'd2,
      S_SUB1 = 3'd3,
      S_SUB2 = 3'd4,
      S_EVAL = 3'd5,
      S_DONE = 3'd6
   } state_t;

   // One decimal digit add/subtract; returns {carry_or_borrow, digit}.
   function automatic logic [4:0] bcd_digit(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin, input logic sub);
      logic [4:0] t;
      if (sub) begin
         t = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
         if (t[4]) return {1'b1, t[3:0] + 4'd10};
         else      return {1'b0, t[3:0]};
      end else begin
         t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
         if (t > 5'd9) return {1'b1, t[3:0] - 4'd10};
         else          return {1'b0, t[3:0]};
      end
   endfunction

   function automatic logic bcd_valid(input logic [11:0] v);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
   endfunction

   state_t         state_r, next_state_s;
   logic [11:0]    new_mag_r, prev_mag_r, op_a_r, op_b_r, value_bcd_r, delta_bcd_r;
   logic           new_sign_r, prev_sign_r, first_r, sub_r, carry_r, dsign_r;
   logic [7:0]     res_r;
   logic [HW-1:0]  hold_cnt_r;
   logic [TW-1:0]  to_cnt_r;
   logic           ready_r, mon_en_r, state_valid_r, bad_r, timeout_r, value_sign_r, delta_sign_r;
   logic [1:0]     state_out_r;
   logic           accept_s, bcd_ok_s, eff_new_neg_s, eff_prev_neg_s, new_lt_s, sub_s;
   logic [3:0]     dig_a_s, dig_b_s;
   logic [4:0]     digit_s;

   assign accept_s     = sample_valid & ready_r;
   assign bcd_ok_s     = bcd_valid(sample_bcd);
   assign sample_ready = ready_r;
   assign mon_en       = mon_en_r;
   assign state_valid  = state_valid_r;
   assign state_out    = state_out_r;
   assign bad_sample   = bad_r;
   assign timeout      = timeout_r;
   assign value_bcd    = value_bcd_r;
   assign value_sign   = value_sign_r;
   assign delta_bcd    = delta_bcd_r;
   assign delta_sign   = delta_sign_r;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= S_IDLE;
      else     state_r <= next_state_s;
   end

   // Next-state sequencing.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s && bcd_ok_s) next_state_s = S_CMP;
            else                      next_state_s = S_IDLE;
         end
         S_CMP:  next_state_s = S_SUB0;
         S_SUB0: next_state_s = S_SUB1;
         S_SUB1: next_state_s = S_SUB2;
         S_SUB2: next_state_s = S_EVAL;
         S_EVAL: begin
            if (hold_cnt_r == HOLD_LAST) next_state_s = S_DONE;
            else                         next_state_s = S_EVAL;
         end
         S_DONE:  next_state_s = S_IDLE;
         default: next_state_s = S_IDLE;
      endcase
   end

   // Signed compare and current digit operation; a zero magnitude counts as positive.
   always_comb begin
      eff_new_neg_s  = new_sign_r & (new_mag_r != 12'h000);
      eff_prev_neg_s = prev_sign_r & (prev_mag_r != 12'h000);
      new_lt_s       = 1'b0;
      sub_s          = 1'b1;
      if (eff_new_neg_s != eff_prev_neg_s) begin
         new_lt_s = eff_new_neg_s;
         sub_s    = 1'b0;
      end else if (eff_new_neg_s) begin
         new_lt_s = (new_mag_r > prev_mag_r);
         sub_s    = 1'b1;
      end else begin
         new_lt_s = (new_mag_r < prev_mag_r);
         sub_s    = 1'b1;
      end
      dig_a_s = op_a_r[3:0];
      dig_b_s = op_b_r[3:0];
      case (state_r)
         S_SUB1: begin
            dig_a_s = op_a_r[7:4];
            dig_b_s = op_b_r[7:4];
         end
         S_SUB2: begin
            dig_a_s = op_a_r[11:8];
            dig_b_s = op_b_r[11:8];
         end
         default: begin
            dig_a_s = op_a_r[3:0];
            dig_b_s = op_b_r[3:0];
         end
      endcase
      digit_s = bcd_digit(dig_a_s, dig_b_s, carry_r, sub_r);
   end

   // Datapath, monitor interface and handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         new_mag_r     <= 12'h000;
         new_sign_r    <= 1'b0;
         prev_mag_r    <= 12'h000;
         prev_sign_r   <= 1'b0;
         first_r       <= 1'b1;
         op_a_r        <= 12'h000;
         op_b_r        <= 12'h000;
         sub_r         <= 1'b0;
         carry_r       <= 1'b0;
         dsign_r       <= 1'b0;
         res_r         <= 8'h00;
         hold_cnt_r    <= '0;
         value_bcd_r   <= 12'h000;
         value_sign_r  <= 1'b0;
         delta_bcd_r   <= 12'h000;
         delta_sign_r  <= 1'b0;
         state_out_r   <= 2'b00;
         ready_r       <= 1'b0;
         mon_en_r      <= 1'b0;
         state_valid_r <= 1'b0;
         bad_r         <= 1'b0;
      end else begin
         ready_r       <= (next_state_s == S_IDLE);
         mon_en_r      <= (next_state_s == S_EVAL);
         state_valid_r <= (next_state_s == S_DONE);
         bad_r         <= accept_s & ~bcd_ok_s;
         case (state_r)
            S_IDLE: begin
               if (accept_s && bcd_ok_s) begin
                  new_mag_r  <= sample_bcd;
                  new_sign_r <= sample_sign;
               end
            end
            S_CMP: begin
               // Subtraction always runs larger minus smaller so the result is a magnitude.
               if (sub_s && (new_mag_r < prev_mag_r)) begin
                  op_a_r <= prev_mag_r;
                  op_b_r <= new_mag_r;
               end else begin
                  op_a_r <= new_mag_r;
                  op_b_r <= prev_mag_r;
               end
               sub_r   <= sub_s;
               carry_r <= 1'b0;
               dsign_r <= new_lt_s;
            end
            S_SUB0: begin
               res_r[3:0] <= digit_s[3:0];
               carry_r    <= digit_s[4];
            end
            S_SUB1: begin
               res_r[7:4] <= digit_s[3:0];
               carry_r    <= digit_s[4];
            end
            S_SUB2: begin
               value_bcd_r  <= new_mag_r;
               value_sign_r <= new_sign_r;
               if (first_r) begin
                  delta_bcd_r  <= 12'h000;
                  delta_sign_r <= 1'b0;
               end else if (!sub_r && digit_s[4]) begin
                  delta_bcd_r  <= 12'h999;
                  delta_sign_r <= dsign_r;
               end else begin
                  delta_bcd_r  <= {digit_s[3:0], res_r};
                  delta_sign_r <= dsign_r;
               end
               prev_mag_r  <= new_mag_r;
               prev_sign_r <= new_sign_r;
               first_r     <= 1'b0;
               hold_cnt_r  <= '0;
            end
            S_EVAL: begin
               if (hold_cnt_r == HOLD_LAST) state_out_r <= mon_state;
               else                         hold_cnt_r  <= hold_cnt_r + HW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Idle watchdog: saturating count of idle cycles, sticky flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_r  <= '0;
         timeout_r <= 1'b0;
      end else if (accept_s) begin
         to_cnt_r  <= '0;
         timeout_r <= 1'b0;
      end else if (state_r == S_IDLE) begin
         if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TW'(1);
            if (TO_ENABLE && ((to_cnt_r + TW'(1)) == TO_LIMIT)) timeout_r <= 1'b1;
         end
      end
   end

endmodule
